// File: rtl/aes_pkg.sv
// Shared AES-128 definitions: round constants, key-schedule FSM states and word helpers.
package aes_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        EXPAND = 2'd1,
        READY  = 2'd2
    } inv_ks_state_t;

    localparam logic [7:0] RCON [1:10] = '{
        8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
    };

    // Out-of-range indices (round 0, idle counter) return zero instead of reading past the table.
    function automatic logic [7:0] rcon_of(input logic [3:0] idx);
        if (idx >= 4'd1 && idx <= 4'd10) return RCON[idx];
        return 8'h00;
    endfunction

    function automatic logic [31:0] rot_word(input logic [31:0] w);
        return {w[23:0], w[31:24]};
    endfunction

    function automatic logic [31:0] xor_words(input logic [31:0] a, input logic [31:0] b);
        return a ^ b;
    endfunction

endpackage

// File: rtl/inv_key_sched_if.sv
// Key-load / round-key bus of the inverse key schedule.
// Optional restart signal present when INV_RESTART_EN is defined.
interface inv_key_sched_if;
    logic         key_load;
    logic [127:0] rx_key;
    logic         step;
`ifdef INV_RESTART_EN
    logic         restart;
`endif
    logic         busy;
    logic         key_valid;
    logic [127:0] cur_key;
    logic [3:0]   cur_round;
    logic [127:0] orig_key;

`ifdef INV_RESTART_EN
    modport master (output key_load, rx_key, step, restart,
                    input  busy, key_valid, cur_key, cur_round, orig_key);
    modport slave  (input  key_load, rx_key, step, restart,
                    output busy, key_valid, cur_key, cur_round, orig_key);
`else
    modport master (output key_load, rx_key, step,
                    input  busy, key_valid, cur_key, cur_round, orig_key);
    modport slave  (input  key_load, rx_key, step,
                    output busy, key_valid, cur_key, cur_round, orig_key);
`endif
endinterface

// File: rtl/SBox.sv
// AES forward S-box, pure combinational table lookup.
module SBox (
    input  logic [7:0] data_in,
    output logic [7:0] data_out
);
    // Entry 0 sits in the top byte, so entry i lives at bit offset 8*(255-i) = 8*~i.
    localparam logic [2047:0] SBOX_TBL = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    // Table read
    always_comb data_out = SBOX_TBL[{~data_in, 3'b000} +: 8];
endmodule

// File: rtl/inv_key_sched_key_word_sub.sv
// SubWord(RotWord(x)): the four shared S-boxes of the key schedule.
module key_word_sub
    import aes_pkg::*;
(
    input  logic [31:0] word_in,
    output logic [31:0] word_out
);
    logic [31:0] rot;

    // Byte rotate ahead of substitution
    always_comb rot = rot_word(word_in);

    for (genvar i = 0; i < 4; i++) begin : g_sbox
        SBox u_sbox (
            .data_in  (rot[8*i +: 8]),
            .data_out (word_out[8*i +: 8])
        );
    end
endmodule

// File: rtl/inv_key_sched.sv
// Inverse AES-128 key schedule: expands a cipher key forward to round 10,
// then steps the round key backwards 10 -> 0 on request.
// Optional feature macro: INV_RESTART_EN (restart input + stored round-10 key).
//
// state  | meaning
// IDLE   | no key loaded, step/restart ignored
// EXPAND | forward expansion, one round per cycle (busy)
// READY  | cur_key/cur_round valid, step walks rounds downward
module inv_key_sched
    import aes_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    inv_key_sched_if.slave    bus
);
    inv_ks_state_t state_q, state_d;
    logic [127:0]  work_q, work_d;
    logic [3:0]    cnt_q, cnt_d;
    logic [127:0]  cur_key_q, cur_key_d;
    logic [3:0]    cur_round_q, cur_round_d;
    logic [127:0]  orig_key_q, orig_key_d;
`ifdef INV_RESTART_EN
    logic [127:0]  last_key_q, last_key_d;
`endif

    logic [31:0]   sub_in, sub_out;
    logic [31:0]   p0, p1, p2, p3;
    logic [31:0]   f0, f1, f2, f3;

    key_word_sub u_kws (
        .word_in  (sub_in),
        .word_out (sub_out)
    );

    // Forward/inverse round datapaths sharing one SubWord unit, operand picked by state
    always_comb begin
        p3 = xor_words(cur_key_q[31:0],  cur_key_q[63:32]);
        p2 = xor_words(cur_key_q[63:32], cur_key_q[95:64]);
        p1 = xor_words(cur_key_q[95:64], cur_key_q[127:96]);
        sub_in = (state_q == READY) ? p3 : work_q[31:0];
        p0 = xor_words(xor_words(cur_key_q[127:96], sub_out), {rcon_of(cur_round_q), 24'h0});
        f0 = xor_words(xor_words(work_q[127:96], sub_out), {rcon_of(cnt_q), 24'h0});
        f1 = xor_words(work_q[95:64], f0);
        f2 = xor_words(work_q[63:32], f1);
        f3 = xor_words(work_q[31:0],  f2);
    end

    // Next-state and register updates; key_load preempts everything from any state
    always_comb begin
        state_d     = state_q;
        work_d      = work_q;
        cnt_d       = cnt_q;
        cur_key_d   = cur_key_q;
        cur_round_d = cur_round_q;
        orig_key_d  = orig_key_q;
`ifdef INV_RESTART_EN
        last_key_d  = last_key_q;
`endif
        if (bus.key_load) begin
            state_d    = EXPAND;
            orig_key_d = bus.rx_key;
            work_d     = bus.rx_key;
            cnt_d      = 4'd1;
        end else begin
            case (state_q)
                EXPAND: begin
                    work_d = {f0, f1, f2, f3};
                    cnt_d  = cnt_q + 4'd1;
                    if (cnt_q == 4'd10) begin
                        state_d     = READY;
                        cur_key_d   = {f0, f1, f2, f3};
                        cur_round_d = 4'd10;
`ifdef INV_RESTART_EN
                        last_key_d  = {f0, f1, f2, f3};
`endif
                    end
                end
                READY: begin
`ifdef INV_RESTART_EN
                    if (bus.restart) begin
                        cur_key_d   = last_key_q;
                        cur_round_d = 4'd10;
                    end else
`endif
                    if (bus.step && cur_round_q != 4'd0) begin
                        cur_key_d   = {p0, p1, p2, p3};
                        cur_round_d = cur_round_q - 4'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            work_q      <= '0;
            cnt_q       <= '0;
            cur_key_q   <= '0;
            cur_round_q <= '0;
            orig_key_q  <= '0;
`ifdef INV_RESTART_EN
            last_key_q  <= '0;
`endif
        end else begin
            state_q     <= state_d;
            work_q      <= work_d;
            cnt_q       <= cnt_d;
            cur_key_q   <= cur_key_d;
            cur_round_q <= cur_round_d;
            orig_key_q  <= orig_key_d;
`ifdef INV_RESTART_EN
            last_key_q  <= last_key_d;
`endif
        end
    end

    assign bus.busy      = (state_q == EXPAND);
    assign bus.key_valid = (state_q == READY);
    assign bus.cur_key   = cur_key_q;
    assign bus.cur_round = cur_round_q;
    assign bus.orig_key  = orig_key_q;
endmodule

// File: tb/tb_inv_key_sched.sv
// Directed bench for inv_key_sched using FIPS-197 and all-zero key schedules.
module tb_inv_key_sched;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp  = 0;
    int   n_fail = 0;

    inv_key_sched_if bus ();

    inv_key_sched u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] FIPS_R10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] ZERO_R10 = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

    typedef struct {
        logic         step;
        logic [3:0]   exp_round;
        logic [127:0] exp_key;
    } vec_t;

    vec_t vecs [12];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_key(input logic [127:0] k);
        bus.rx_key   = k;
        bus.key_load = 1'b1;
        tick();
        bus.key_load = 1'b0;
    endtask

    // Counts edges after the load edge until busy drops; bounded.
    task automatic wait_ready(output int cyc);
        cyc = 0;
        do begin
            tick();
            cyc++;
        end while (bus.busy && cyc < 30);
        if (bus.busy) cyc = -1;
    endtask

    task automatic do_steps(input int n);
        for (int i = 0; i < n; i++) begin
            bus.step = 1'b1;
            tick();
        end
        bus.step = 1'b0;
    endtask

    initial begin
        int cyc;
        bus.key_load = 1'b0;
        bus.rx_key   = '0;
        bus.step     = 1'b0;
`ifdef INV_RESTART_EN
        bus.restart  = 1'b0;
`endif
        vecs[0]  = '{1'b0, 4'd10, FIPS_R10};
        vecs[1]  = '{1'b1, 4'd9,  128'hac7766f319fadc2128d12941575c006e};
        vecs[2]  = '{1'b1, 4'd8,  128'head27321b58dbad2312bf5607f8d292f};
        vecs[3]  = '{1'b1, 4'd7,  128'h4e54f70e5f5fc9f384a64fb24ea6dc4f};
        vecs[4]  = '{1'b1, 4'd6,  128'h6d88a37a110b3efddbf98641ca0093fd};
        vecs[5]  = '{1'b1, 4'd5,  128'hd4d1c6f87c839d87caf2b8bc11f915bc};
        vecs[6]  = '{1'b1, 4'd4,  128'hef44a541a8525b7fb671253bdb0bad00};
        vecs[7]  = '{1'b1, 4'd3,  128'h3d80477d4716fe3e1e237e446d7a883b};
        vecs[8]  = '{1'b1, 4'd2,  128'hf2c295f27a96b9435935807a7359f67f};
        vecs[9]  = '{1'b1, 4'd1,  128'ha0fafe1788542cb123a339392a6c7605};
        vecs[10] = '{1'b1, 4'd0,  FIPS_KEY};
        vecs[11] = '{1'b1, 4'd0,  FIPS_KEY};

        tick();
        tick();
        rst = 1'b0;
        check("rst_busy",      128'(bus.busy),      128'd0);
        check("rst_key_valid", 128'(bus.key_valid), 128'd0);
        check("rst_round",     128'(bus.cur_round), 128'd0);
        check("rst_cur_key",   bus.cur_key,         128'd0);
        check("rst_orig_key",  bus.orig_key,        128'd0);

        do_steps(1);
        check("idle_step_valid", 128'(bus.key_valid), 128'd0);
        check("idle_step_round", 128'(bus.cur_round), 128'd0);

        load_key(FIPS_KEY);
        check("load_busy", 128'(bus.busy), 128'd1);
        wait_ready(cyc);
        check("load_latency", 128'(cyc),           128'd10);
        check("ready_busy",   128'(bus.busy),      128'd0);
        check("ready_valid",  128'(bus.key_valid), 128'd1);
        check("ready_orig",   bus.orig_key,        FIPS_KEY);

        for (int i = 0; i < 12; i++) begin
            bus.step = vecs[i].step;
            tick();
            bus.step = 1'b0;
            check($sformatf("vec%0d_round", i), 128'(bus.cur_round), 128'(vecs[i].exp_round));
            check($sformatf("vec%0d_key", i),   bus.cur_key,         vecs[i].exp_key);
        end

        // Abort an in-flight expansion with an all-zero key
        load_key(FIPS_KEY);
        repeat (4) tick();
        load_key(128'd0);
        check("abort_busy", 128'(bus.busy), 128'd1);
        wait_ready(cyc);
        check("abort_latency", 128'(cyc),           128'd10);
        check("abort_round",   128'(bus.cur_round), 128'd10);
        check("abort_key",     bus.cur_key,         ZERO_R10);
        check("abort_orig",    bus.orig_key,        128'd0);

        // key_load beats step in READY; key_valid drops on that edge
        bus.step = 1'b1;
        load_key(FIPS_KEY);
        bus.step = 1'b0;
        check("kl_step_valid", 128'(bus.key_valid), 128'd0);
        check("kl_step_busy",  128'(bus.busy),      128'd1);
        check("kl_step_round", 128'(bus.cur_round), 128'd10);
        wait_ready(cyc);
        check("reload_key", bus.cur_key, FIPS_R10);

        // Reset mid-READY at round 4
        do_steps(6);
        check("pre_rst_round", 128'(bus.cur_round), 128'd4);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid_rst_key",   bus.cur_key,         128'd0);
        check("mid_rst_orig",  bus.orig_key,        128'd0);
        check("mid_rst_valid", 128'(bus.key_valid), 128'd0);
        do_steps(1);
        check("post_rst_step_round", 128'(bus.cur_round), 128'd0);
        check("post_rst_step_busy",  128'(bus.busy),      128'd0);

`ifdef INV_RESTART_EN
        load_key(FIPS_KEY);
        wait_ready(cyc);
        do_steps(7);
        check("pre_restart_key", bus.cur_key, 128'h3d80477d4716fe3e1e237e446d7a883b);
        bus.restart = 1'b1;
        bus.step    = 1'b1;
        tick();
        bus.restart = 1'b0;
        bus.step    = 1'b0;
        check("restart_round", 128'(bus.cur_round), 128'd10);
        check("restart_key",   bus.cur_key,         FIPS_R10);
        check("restart_valid", 128'(bus.key_valid), 128'd1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/inv_key_sched.md
# inv_key_sched

Inverse AES-128 key schedule for the decryption datapath. A 128-bit cipher key is loaded, expanded forward internally to the round-10 key, and the round keys are then presented one at a time in descending order (10 down to 0) on single-cycle `step` requests. The block sits between the key receive shift register and the decryption AddRoundKey stage. It is the reverse-order counterpart of the encryption-side round key generator.

## Interface
- No parameters; AES-128 only (Nk=4, Nr=10).
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `key_load`  in  1  load `rx_key` as the new cipher key and start expansion.
- `rx_key`  in  128  cipher key; word 0 = [127:96].
- `step`  in  1  request the previous round key (round r → r-1).
- `restart`  in  1  re-present the round-10 key; only exists under `INV_RESTART_EN`.
- `busy`  out  1  forward expansion in progress.
- `key_valid`  out  1  `cur_key`/`cur_round` hold a valid round key.
- `cur_key`  out  128  current round key, to AddRoundKey.
- `cur_round`  out  4  round index of `cur_key`, range 10..0.
- `orig_key`  out  128  stored cipher key (round-0 key).

## Operation
- FSM states: IDLE, EXPAND, READY. Reset state is IDLE.
- Reset values:
  - `busy` = 0, `key_valid` = 0, `cur_round` = 0.
  - `cur_key` = 0, `orig_key` = 0.
  - All internal registers cleared.
- IDLE:
  - `key_load` → EXPAND; latch `orig_key <= rx_key` and `work <= rx_key`; set `cnt <= 1`.
  - `step` and `restart` are ignored.
- EXPAND (`busy` = 1):
  - Each cycle, apply the forward step `work <= fwd(work, rcon[cnt])`.
  - `fwd`: w0' = w0 ^ SubWord(RotWord(w3)) ^ {rcon, 24'h0}; w1' = w1 ^ w0'; w2' = w2 ^ w1'; w3' = w3 ^ w2'.
  - When `cnt` == 10, go to READY. On that edge load `cur_key` = fwd result, `last_key` = fwd result, and `cur_round` = 10.
- READY (`key_valid` = 1):
  - `step` with `cur_round` > 0: `cur_key <= inv(cur_key, rcon[cur_round])`, `cur_round <= cur_round - 1`.
  - `inv`: p3 = w3 ^ w2; p2 = w2 ^ w1; p1 = w1 ^ w0; p0 = w0 ^ SubWord(RotWord(p3)) ^ {rcon, 24'h0}.
  - `step` at `cur_round` == 0: ignored; key and round hold.
- Key-change rules:
  - `key_load` in EXPAND or READY aborts the current sequence and restarts expansion with the new key. `key_valid` drops on the next edge.
  - `key_load` and `step` (or `restart`) in the same cycle: `key_load` wins.
- Rcon table (indices 1..10): 01, 02, 04, 08, 10, 20, 40, 80, 1B, 36.
- The four SBox lookups are shared between the forward and inverse paths. The operand is muxed by state: `work[31:0]` in EXPAND, `p3` in READY.

## Timing
- Load latency:
  - `key_load` sampled at edge E0.
  - `busy` = 1 after E0 through edge E10.
  - After E10: `busy` = 0, `key_valid` = 1, `cur_round` = 10.
  - A new key is therefore usable 10 cycles after load.
- `step` latency is 1 cycle. `cur_key`/`cur_round` update on the sampling edge, allowing one step per cycle.
- Round 10 → round 0 takes 10 consecutive steps. Round 0 equals `orig_key` bit-exactly.
- All outputs are registered; there are no combinational input-to-output paths.
- `rst` mid-EXPAND or mid-READY returns the block to IDLE with reset values on the next edge.

## Configuration
- `INV_RESTART_EN` defined:
  - The `restart` port exists.
  - In READY, `restart` loads `cur_key <= last_key` and `cur_round <= 10` in 1 cycle, so the next ciphertext block needs no re-expansion.
  - `restart` together with `step`: `restart` wins.
- `INV_RESTART_EN` undefined:
  - No `restart` port and no `last_key` register.
  - A new block requires `key_load` and a new 10-cycle expansion.

## Structure
- Shared package `aes_pkg`:
  - Rcon table as a constant array indexed 1..10.
  - FSM state enum `inv_ks_state_t`.
  - Functions `rot_word` and `xor_words`.
- Reuse the existing `SBox` module (ports `data_in`, `data_out`), four instances.
- One natural sub-module: `key_word_sub`, wrapping the four SBoxes plus RotWord. It takes a 32-bit word in and produces SubWord(RotWord(x)).

## Test plan
- FIPS-197 key `2b7e151628aed2a6abf7158809cf4f3c` loaded → after 10 cycles `busy` = 0, `key_valid` = 1, `cur_round` = 10, `cur_key` = `d014f9a8c9ee2589e13f0cc8b6630ca6`.
- One `step` → `cur_round` = 9, `cur_key` = `ac7766f319fadc2128d12941575c006e`.
- Ten back-to-back `step` pulses → `cur_round` = 0, `cur_key` = `2b7e1516…4f3c` = `orig_key`; an 11th `step` leaves both unchanged.
- `key_load` of an all-zero key issued at cycle 5 of an expansion → expansion restarts, and the round-10 key `b4ef5bcb3e92e21123e951cf6f8f188e` appears 10 cycles later.
- `rst` asserted while `cur_round` = 4 → next cycle all outputs 0 and FSM in IDLE; `step` is then ignored.
- With `INV_RESTART_EN`: at `cur_round` = 3, assert `restart` with `step` → `cur_round` = 10, `cur_key` = `d014…0ca6` next cycle.
